// File: rtl/color_filter_if.sv
// Bus bundle between the colour filter and Core: raw colour codes and acks in,
// debounced colours, new-colour flags and match out.
interface color_filter_if;
    logic [1:0] object_color;
    logic [1:0] station_color;
    logic       obj_ack;
    logic       stn_ack;
    logic [1:0] obj_stable;
    logic [1:0] stn_stable;
    logic       obj_new;
    logic       stn_new;
    logic       match;

    modport master (
        output object_color, station_color, obj_ack, stn_ack,
        input  obj_stable, stn_stable, obj_new, stn_new, match
    );

    modport slave (
        input  object_color, station_color, obj_ack, stn_ack,
        output obj_stable, stn_stable, obj_new, stn_new, match
    );
endinterface

// File: rtl/color_filter.sv
// Debounces the object and station colour codes once per sample frame and
// publishes stable codes, held new-colour flags with ack, and a match flag.
module color_filter #(
    parameter int unsigned SAMPLE_PERIOD = 8000,
    parameter int unsigned STABLE_COUNT  = 3,
    parameter int unsigned TMR_W         = 13
) (
    input  logic         clkus,
    input  logic         rst,
    color_filter_if.slave bus
);

    logic [TMR_W-1:0] r_tmr;
    logic             w_tick;

    // Channel 0 is the object, channel 1 the station.
    logic [1:0] w_in     [2];
    logic       w_ack    [2];
    logic [1:0] r_cand   [2];
    logic [3:0] r_run    [2];
    logic [1:0] r_stable [2];
    logic       r_new    [2];
    logic [1:0] w_cand_n   [2];
    logic [3:0] w_run_n    [2];
    logic [1:0] w_stable_n [2];
    logic       w_new_n    [2];
    logic       w_match_n;
    logic       r_match;

    assign w_tick = (r_tmr == TMR_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clkus or posedge rst) begin
        if (rst)
            r_tmr <= '0;
        else if (w_tick)
            r_tmr <= '0;
        else
            r_tmr <= r_tmr + TMR_W'(1);
    end

    assign w_in[0]  = bus.object_color;
    assign w_in[1]  = bus.station_color;
    assign w_ack[0] = bus.obj_ack;
    assign w_ack[1] = bus.stn_ack;

    // Stable loads on the same edge the run counter reaches the threshold,
    // so the threshold test uses the post-update candidate and run.
    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            w_cand_n[ch]   = r_cand[ch];
            w_run_n[ch]    = r_run[ch];
            w_stable_n[ch] = r_stable[ch];
            w_new_n[ch]    = r_new[ch];
            if (w_tick) begin
                if (w_in[ch] == r_cand[ch]) begin
                    w_run_n[ch] = (r_run[ch] == 4'd15) ? 4'd15 : r_run[ch] + 4'd1;
                end else begin
                    w_cand_n[ch] = w_in[ch];
                    w_run_n[ch]  = 4'd1;
                end
            end
            if (w_tick && (w_run_n[ch] >= 4'(STABLE_COUNT)) && (w_cand_n[ch] != r_stable[ch]))
                w_stable_n[ch] = w_cand_n[ch];
            if ((w_stable_n[ch] != r_stable[ch]) && (w_stable_n[ch] != 2'd0))
                w_new_n[ch] = 1'b1;
            else if (w_ack[ch])
                w_new_n[ch] = 1'b0;
        end
        w_match_n = (w_stable_n[0] != 2'd0) && (w_stable_n[0] == w_stable_n[1]);
    end

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_cand[ch]   <= '0;
                r_run[ch]    <= '0;
                r_stable[ch] <= '0;
                r_new[ch]    <= 1'b0;
            end
            r_match <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_cand[ch]   <= w_cand_n[ch];
                r_run[ch]    <= w_run_n[ch];
                r_stable[ch] <= w_stable_n[ch];
                r_new[ch]    <= w_new_n[ch];
            end
            r_match <= w_match_n;
        end
    end

    assign bus.obj_stable = r_stable[0];
    assign bus.stn_stable = r_stable[1];
    assign bus.obj_new    = r_new[0];
    assign bus.stn_new    = r_new[1];
    assign bus.match      = r_match;

endmodule
